// File: rtl/fall_sched_ctrl_if.sv
// Signal bundle between the fall scheduler and the board logic.
// Every i_* pulse is a one-cycle strobe sampled on the rising clock; i_lines_cleared is
// meaningful only while i_lines_valid is high; i_pause, i_down_btn and i_landed are
// levels. Every o_* pulse is a registered one-cycle strobe with no back-pressure.
interface fall_sched_ctrl_if;
  logic       i_game_start;
  logic       i_game_over;
  logic       i_pause;
  logic       i_down_btn;
  logic       i_hard_drop;
  logic       i_landed;
  logic       i_piece_moved;
  logic       i_spawn_done;
  logic       i_lines_valid;
  logic [2:0] i_lines_cleared;
  logic       o_fall_tick;
  logic       o_lock_req;
  logic       o_spawn_req;
  logic [3:0] o_level;
  logic [9:0] o_lines;
  logic [2:0] o_state;

  modport master (
    output i_game_start, i_game_over, i_pause, i_down_btn, i_hard_drop, i_landed,
           i_piece_moved, i_spawn_done, i_lines_valid, i_lines_cleared,
    input  o_fall_tick, o_lock_req, o_spawn_req, o_level, o_lines, o_state
  );

  modport slave (
    input  i_game_start, i_game_over, i_pause, i_down_btn, i_hard_drop, i_landed,
           i_piece_moved, i_spawn_done, i_lines_valid, i_lines_cleared,
    output o_fall_tick, o_lock_req, o_spawn_req, o_level, o_lines, o_state
  );
endinterface

// File: rtl/fall_sched_ctrl.sv
// Piece-fall scheduler: sequences fall, lock-delay, hard-drop and spawn phases, and
// tracks lines/level to derive the gravity period.
module fall_sched_ctrl #(
  parameter int BASE_CNT        = 75000000 - 1,
  parameter int LEVEL_STEP      = 5000000,
  parameter int MIN_CNT         = 5000000 - 1,
  parameter int SOFT_CNT        = 5000000 - 1,
  parameter int LOCK_CNT        = 37500000 - 1,
  parameter int HARD_GAP        = 1,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 14,
  parameter int MAX_LOCK_RESETS = 15
) (
  input logic              i_pixclk,
  input logic              i_reset_n,
  fall_sched_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FALL       = 3'd1,
    S_LOCK_WAIT  = 3'd2,
    S_HARD       = 3'd3,
    S_SPAWN_WAIT = 3'd4
  } state_t;

  localparam int HW = $clog2(HARD_GAP + 2);
  localparam int RW = $clog2(MAX_LOCK_RESETS + 2);

  localparam logic [27:0]   BASE_W    = 28'(BASE_CNT);
  localparam logic [27:0]   STEP_W    = 28'(LEVEL_STEP);
  localparam logic [27:0]   MIN_W     = 28'(MIN_CNT);
  localparam logic [27:0]   SOFT_W    = 28'(SOFT_CNT);
  localparam logic [26:0]   LOCK_W    = 27'(LOCK_CNT);
  localparam logic [HW-1:0] GAP_W     = HW'(HARD_GAP);
  localparam logic [RW-1:0] RESETS_W  = RW'(MAX_LOCK_RESETS);
  localparam logic [7:0]    LPL_W     = 8'(LINES_PER_LEVEL);
  localparam logic [3:0]    MAXL_W    = 4'(MAX_LEVEL);
  localparam logic [10:0]   LINES_SAT = 11'd999;

  state_t          state_q, state_d;
  logic [26:0]     fall_cnt_q, fall_cnt_d;
  logic [26:0]     lock_cnt_q, lock_cnt_d;
  logic [HW-1:0]   hard_cnt_q, hard_cnt_d;
  logic [RW-1:0]   resets_q, resets_d;
  logic            spawn_pend_q, spawn_pend_d;
  logic [3:0]      level_q, level_d;
  logic [9:0]      lines_q, lines_d;
  logic [7:0]      in_lvl_q, in_lvl_d;
  logic            fall_tick_q, fall_tick_d;
  logic            lock_req_q, lock_req_d;
  logic            spawn_req_q, spawn_req_d;

  logic [27:0]     level_dec, period_raw, period, target;
  logic [10:0]     lines_sum;
  logic [7:0]      in_lvl_sum;

  // Gravity target; the subtraction is guarded so high levels clamp to MIN_CNT.
  always_comb begin
    level_dec  = 28'(level_q) * STEP_W;
    period_raw = (level_dec >= BASE_W) ? 28'd0 : (BASE_W - level_dec);
    period     = (period_raw > MIN_W) ? period_raw : MIN_W;
    target     = period;
    if (bus.i_down_btn && (SOFT_W < period)) target = SOFT_W;
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      fall_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      hard_cnt_q   <= '0;
      resets_q     <= '0;
      spawn_pend_q <= 1'b0;
      level_q      <= '0;
      lines_q      <= '0;
      in_lvl_q     <= '0;
      fall_tick_q  <= 1'b0;
      lock_req_q   <= 1'b0;
      spawn_req_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fall_cnt_q   <= fall_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      hard_cnt_q   <= hard_cnt_d;
      resets_q     <= resets_d;
      spawn_pend_q <= spawn_pend_d;
      level_q      <= level_d;
      lines_q      <= lines_d;
      in_lvl_q     <= in_lvl_d;
      fall_tick_q  <= fall_tick_d;
      lock_req_q   <= lock_req_d;
      spawn_req_q  <= spawn_req_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fall_cnt_d   = fall_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    hard_cnt_d   = hard_cnt_q;
    resets_d     = resets_q;
    spawn_pend_d = spawn_pend_q;
    level_d      = level_q;
    lines_d      = lines_q;
    in_lvl_d     = in_lvl_q;
    fall_tick_d  = 1'b0;
    lock_req_d   = 1'b0;
    spawn_req_d  = 1'b0;
    lines_sum    = {1'b0, lines_q} + 11'(bus.i_lines_cleared);
    in_lvl_sum   = in_lvl_q + 8'(bus.i_lines_cleared);

    if (bus.i_game_start) begin
      state_d      = S_SPAWN_WAIT;
      fall_cnt_d   = '0;
      lock_cnt_d   = '0;
      hard_cnt_d   = '0;
      resets_d     = '0;
      spawn_pend_d = 1'b0;
      level_d      = '0;
      lines_d      = '0;
      in_lvl_d     = '0;
      spawn_req_d  = 1'b1;
    end else if (bus.i_game_over && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      spawn_pend_d = 1'b0;
    end else if (!bus.i_pause) begin
      if (bus.i_lines_valid && (state_q != S_IDLE)) begin
        lines_d = (lines_sum > LINES_SAT) ? LINES_SAT[9:0] : lines_sum[9:0];
        if (in_lvl_sum >= LPL_W) begin
          in_lvl_d = in_lvl_sum - LPL_W;
          level_d  = (level_q >= MAXL_W) ? MAXL_W : (level_q + 4'd1);
        end else begin
          in_lvl_d = in_lvl_sum;
        end
      end

      case (state_q)
        S_SPAWN_WAIT: begin
          // After a lock the spawn request trails o_lock_req by one cycle.
          if (spawn_pend_q) begin
            spawn_req_d  = 1'b1;
            spawn_pend_d = 1'b0;
          end else if (bus.i_spawn_done) begin
            state_d    = S_FALL;
            fall_cnt_d = '0;
            resets_d   = '0;
          end
        end
        S_FALL: begin
          if (bus.i_hard_drop) begin
            state_d    = S_HARD;
            hard_cnt_d = '0;
          end else if (bus.i_landed) begin
            state_d    = S_LOCK_WAIT;
            lock_cnt_d = '0;
          end else if ({1'b0, fall_cnt_q} >= target) begin
            fall_cnt_d  = '0;
            fall_tick_d = 1'b1;
          end else begin
            fall_cnt_d = fall_cnt_q + 27'd1;
          end
        end
        S_LOCK_WAIT: begin
          if (!bus.i_landed) begin
            state_d = S_FALL;
          end else if (bus.i_down_btn || bus.i_hard_drop) begin
            lock_req_d   = 1'b1;
            state_d      = S_SPAWN_WAIT;
            spawn_pend_d = 1'b1;
          end else if (bus.i_piece_moved && (resets_q < RESETS_W)) begin
            lock_cnt_d = '0;
            resets_d   = resets_q + RW'(1);
          end else if (lock_cnt_q >= LOCK_W) begin
            lock_req_d   = 1'b1;
            state_d      = S_SPAWN_WAIT;
            spawn_pend_d = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + 27'd1;
          end
        end
        S_HARD: begin
          if (bus.i_landed) begin
            lock_req_d   = 1'b1;
            state_d      = S_SPAWN_WAIT;
            spawn_pend_d = 1'b1;
          end else if (hard_cnt_q >= GAP_W) begin
            hard_cnt_d  = '0;
            fall_tick_d = 1'b1;
          end else begin
            hard_cnt_d = hard_cnt_q + HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_fall_tick = fall_tick_q;
  assign bus.o_lock_req  = lock_req_q;
  assign bus.o_spawn_req = spawn_req_q;
  assign bus.o_level     = level_q;
  assign bus.o_lines     = lines_q;
  assign bus.o_state     = state_q;

endmodule
